// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and line levels shared by the UART transmitter and receiver.
//   tx_state_t     : transmitter FSM states
//   UART_IDLE_LVL  : level of an idle line and of stop bits
//   UART_START_LVL : level of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Valid/ready byte handshake into the UART transmitter.
//   tx_data  : byte to send, sampled only on the accepting edge
//   tx_valid : tx_data valid
//   tx_ready : transmitter can accept a byte
// Modports: master (byte producer), slave (uart_tx).
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_bclk_edge.sv
// -----------------------------------------------------------------------------
// uart_bclk_edge
// Registers the baud square wave and flags its rising edge with a one-clk tick.
// bclk is already in the clk domain, so no synchroniser is needed.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bclk_i : baud square wave, one period per bit time
//   tick_o : high for one clk on each bclk rising edge
// -----------------------------------------------------------------------------
module uart_bclk_edge (
    input  logic clk,
    input  logic reset,
    input  logic bclk_i,
    output logic tick_o
);

    logic bclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_q <= 1'b0;
        end else begin
            bclk_q <= bclk_i;
        end
    end

    assign tick_o = bclk_i & ~bclk_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Accepts a byte over a valid/ready handshake and
// shifts it out LSB-first as start / data / [parity] / stop bits, one bit per
// bclk period. The line idles high.
//
// Parameters:
//   DATA_BITS  : data bits per frame (5..9)
//   STOP_BITS  : stop bits per frame (1 or 2)
//   PARITY_ODD : 0 = even, 1 = odd parity (parity build only)
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   bclk    : baud square wave from the rate generator, clk domain
//   bus     : uart_tx_if slave (tx_data, tx_valid, tx_ready)
//   tx      : registered serial output
//   tx_busy : a frame is pending or on the line
// Build option:
//   UART_TX_PARITY_EN : when defined, a parity bit is inserted after the data.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     bclk,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     tx_busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $fatal(1, "uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic tick;

    tx_state_t            state_q,    state_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q,       tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q,      par_d;
`endif

    uart_bclk_edge u_bclk_edge (
        .clk    (clk),
        .reset  (reset),
        .bclk_i (bclk),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // tx_d is the level for the bit interval that begins on this tick, so the
    // line only ever moves in the cycle after a tick.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                // Ready is high only here, so valid alone means a transfer.
                // A tick in the same cycle is deliberately dropped.
                if (bus.tx_valid) begin
                    state_d = PEND;
                    shreg_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            PEND: begin
                if (tick) begin
                    state_d = START;
                    tx_d    = UART_START_LVL;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
                        tx_d       = par_q;
`else
                        state_d    = STOP;
                        tx_d       = UART_IDLE_LVL;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shreg_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    tx_d       = UART_IDLE_LVL;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign tx_busy      = (state_q != IDLE);
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Two transmitters side by side: instance 0 with one stop bit and even parity,
// instance 1 with two stop bits and odd parity. A frame-level reference model
// per instance turns each accepted byte into its list of line bits and
// advances one bit per bclk rising edge; every cycle the outputs are compared
// against it. Directed frames with hand-written bit patterns pin the model,
// followed by randomized traffic on both instances.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NI = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk   = 1'b0;
    logic       reset;
    logic       bclk  = 1'b0;
    bit         stall = 1'b0;
    int         bcnt  = 0;
    logic       vld [NI];
    logic [7:0] dat [NI];
    wire        txl [NI];
    wire        rdy [NI];
    wire        bsy [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 16 clk per bit: bclk toggles every 8 clk unless stalled.
    always @(negedge clk) begin
        if (!stall) begin
            if (bcnt == 7) begin
                bcnt = 0;
                bclk = ~bclk;
            end else begin
                bcnt++;
            end
        end
    end

    function automatic void check(input int i, input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %b, expected %b", nm, i, $time, act, exp);
        end
    endfunction

    function automatic void timeout(input int i, input string nm);
        checks++;
        errors++;
        $display("FAIL %s inst%0d at %0t: wait bound expired", nm, i, $time);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_if #(.DATA_BITS(8)) bus ();

        assign bus.tx_valid = vld[g];
        assign bus.tx_data  = dat[g];
        assign rdy[g]       = bus.tx_ready;

        uart_tx #(
            .DATA_BITS  (8),
            .STOP_BITS  (g + 1),
            .PARITY_ODD (g)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .bclk    (bclk),
            .bus     (bus),
            .tx      (txl[g]),
            .tx_busy (bsy[g])
        );

        // Reference model: idle flag, current line level, queue of bits still
        // to be put on the line for the accepted frame.
        bit m_idle = 1'b1;
        bit m_line = 1'b1;
        bit m_prev = 1'b0;
        bit q [$];

        initial begin
            bit tk;
            forever begin
                @(posedge clk or posedge reset);
                if (reset) begin
                    m_idle = 1'b1;
                    m_line = 1'b1;
                    m_prev = 1'b0;
                    q.delete();
                end else begin
                    tk     = bclk & ~m_prev;
                    m_prev = bclk;
                    if (m_idle) begin
                        if (vld[g]) begin
                            q.delete();
                            q.push_back(1'b0);
                            for (int k = 0; k < 8; k++) q.push_back(dat[g][k]);
`ifdef UART_TX_PARITY_EN
                            q.push_back((^dat[g]) ^ (g == 1));
`endif
                            for (int k = 0; k < g + 1; k++) q.push_back(1'b1);
                            m_idle = 1'b0;
                        end
                    end else if (tk) begin
                        if (q.size() > 0) m_line = q.pop_front();
                        else m_idle = 1'b1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            check(g, "tx", txl[g], m_line);
            check(g, "tx_ready", rdy[g], m_idle);
            check(g, "tx_busy", bsy[g], !m_idle);
        end
    end

    // Present a byte and hold valid until the transfer edge; returns on the
    // negedge just after that edge.
    task automatic send(input int i, input logic [7:0] d, input bit keep);
        int n = 0;
        vld[i] = 1'b1;
        dat[i] = d;
        while (!rdy[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout(i, "send");
        @(negedge clk);
        if (!keep) begin
            vld[i] = 1'b0;
            dat[i] = 8'($urandom);
        end
    endtask

    task automatic wait_low(input int i, input string nm);
        int n = 0;
        while (txl[i] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout(i, nm);
    endtask

    // pat[b] is the level of line bit b (bit 0 = start); each lasts 16 clk,
    // and tx_ready must be high right after the last one.
    task automatic expect_frame(input int i, input logic [15:0] pat, input int nbits, input string nm);
        wait_low(i, nm);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 16; c++) begin
                check(i, nm, txl[i], pat[b]);
                @(negedge clk);
            end
        end
        check(i, {nm, "_ready"}, rdy[i], 1'b1);
    endtask

    task automatic stream(input int i, input int nb);
        bit keep = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (!keep) repeat ($urandom_range(0, 40)) @(negedge clk);
            keep = 1'($urandom_range(0, 1));
            send(i, 8'($urandom), keep);
        end
        vld[i] = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog at %0t: simulation did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int n;
        reset  = 1'b1;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        dat[0] = 8'h00;
        dat[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check(i, "rst_tx", txl[i], 1'b1);
            check(i, "rst_ready", rdy[i], 1'b1);
            check(i, "rst_busy", bsy[i], 1'b0);
        end
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);

        // 0x55, LSB first
        send(0, 8'h55, 1'b0);
        expect_frame(0, (PB != 0) ? 16'h04AA : 16'h02AA, 10 + PB, "t1_55");

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07, 1'b0);
        expect_frame(0, 16'h060E, 11, "t2_07_even");
        send(1, 8'h07, 1'b0);
        expect_frame(1, 16'h0C0E, 12, "t2_07_odd");
`endif

        // Valid held: 0xA3 then 0x3C with no gap in tx_valid
        send(0, 8'hA3, 1'b1);
        fork
            send(0, 8'h3C, 1'b0);
            begin
                expect_frame(0, (PB != 0) ? 16'h0546 : 16'h0346, 10 + PB, "t3_a3");
                gap = 0;
                while (txl[0] === 1'b1 && gap < 400) begin
                    gap++;
                    @(negedge clk);
                end
                check(0, $sformatf("t3_gap_ge16(gap=%0d)", gap), gap >= 16, 1'b1);
                expect_frame(0, (PB != 0) ? 16'h0478 : 16'h0278, 10 + PB, "t3_3c");
            end
        join

        // Reset inside a start bit: line must jump high without a clock edge
        send(1, 8'h5A, 1'b0);
        wait_low(1, "t4_start");
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 check(1, "t4_async_tx", txl[1], 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset inside data bit 3 of 0xFF, then a clean 0x00 frame
        send(0, 8'hFF, 1'b0);
        wait_low(0, "t4_ff");
        repeat (69) @(negedge clk);
        #2 reset = 1'b1;
        #1 check(0, "t4_rst_tx", txl[0], 1'b1);
        check(0, "t4_rst_busy", bsy[0], 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check(0, "t4_ready_after", rdy[0], 1'b1);
        send(0, 8'h00, 1'b0);
        expect_frame(0, (PB != 0) ? 16'h0400 : 16'h0200, 10 + PB, "t4_00");

        // Two stop bits, 0x80
        send(1, 8'h80, 1'b0);
        expect_frame(1, (PB != 0) ? 16'h0D00 : 16'h0700, 11 + PB, "t5_80");

        // bclk frozen for 100 clk inside data bit 4 (a 0) of 0x0F
        send(0, 8'h0F, 1'b0);
        wait_low(0, "t6_0f");
        repeat (88) @(negedge clk);
        stall = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check(0, "t6_stall_tx", txl[0], 1'b0);
            check(0, "t6_stall_busy", bsy[0], 1'b1);
        end
        stall = 1'b0;
        n = 0;
        while (!rdy[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(0, "t6_resumed", rdy[0], 1'b1);

        // Randomized traffic on both instances
        fork
            stream(0, 25);
            stream(1, 25);
        join
        n = 0;
        while ((!rdy[0] || !rdy[1]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(0, "final_idle", rdy[0] & rdy[1], 1'b1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
